// File: rtl/srb_mp.sv
`default_nettype none
// ============================================================================
// Module      : srb_mp
// Description : Multi-port sparse read buffer. Entries are written in order into
//               a circular buffer and released out of order by slot index. The
//               optional synchronous flush port is enabled by SRB_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module srb_mp #(
    parameter  int DATA_WIDTH = 32,
    parameter  int SRB_DEPTH  = 8,
    parameter  int RD_PORTS   = 2,
    localparam int IW         = $clog2(SRB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef SRB_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         w_req_valid,
    output logic                         w_req_ready,
    input  logic [DATA_WIDTH-1:0]        w_req_data,
    output logic [IW-1:0]                w_req_idx,
    input  logic [RD_PORTS-1:0]          r_req_valid,
    input  logic [RD_PORTS*IW-1:0]       r_req_idx,
    output logic [RD_PORTS-1:0]          r_req_ready,
    output logic [RD_PORTS-1:0]          r_rsp_valid,
    output logic [RD_PORTS*DATA_WIDTH-1:0] r_rsp_data,
    input  logic [RD_PORTS-1:0]          r_rsp_ready,
    output logic [SRB_DEPTH-1:0]         entry_valid,
    output logic [IW-1:0]                bottom_id,
    output logic [IW:0]                  used
);

    localparam logic [IW:0] c_FULL = (IW+1)'(SRB_DEPTH);

    logic [IW:0]            r_w_ptr;
    logic [IW:0]            r_btm_ptr;
    logic [SRB_DEPTH-1:0]   r_entry_valid;
    logic [DATA_WIDTH-1:0]  r_entry [SRB_DEPTH];

    logic                   w_flush;
    logic [IW:0]            w_used;
    logic                   w_fire;
    logic [IW:0]            w_w_ptr_nxt;
    logic [SRB_DEPTH-1:0]   w_wr_mask;
    logic [SRB_DEPTH-1:0]   w_release;
    logic [SRB_DEPTH-1:0]   w_entry_valid_nxt;
    logic [IW:0]            w_btm_ptr_nxt;
    logic [IW:0]            w_dist;
    logic [IW:0]            w_cand;
    logic                   w_found;
    logic                   w_lost;
    logic [IW-1:0]          w_ridx [RD_PORTS];

`ifdef SRB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_used      = r_w_ptr - r_btm_ptr;
    assign w_req_ready = (w_used != c_FULL) & ~w_flush;
    assign w_fire      = w_req_valid & w_req_ready;
    assign w_w_ptr_nxt = r_w_ptr + {{IW{1'b0}}, w_fire};
    assign w_wr_mask   = w_fire ? ({{(SRB_DEPTH-1){1'b0}}, 1'b1} << r_w_ptr[IW-1:0])
                                : '0;

    assign w_req_idx   = r_w_ptr[IW-1:0];
    assign bottom_id   = r_btm_ptr[IW-1:0];
    assign used        = w_used;
    assign entry_valid = r_entry_valid;
    assign r_req_ready = r_rsp_ready;

    generate
        for (genvar gp = 0; gp < RD_PORTS; gp++) begin : g_ridx
            assign w_ridx[gp] = r_req_idx[gp*IW +: IW];
        end
    endgenerate

    // Lowest-numbered port wins a slot; losers see no response this cycle.
    always_comb begin
        w_lost      = 1'b0;
        w_release   = '0;
        r_rsp_valid = '0;
        r_rsp_data  = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            w_lost = 1'b0;
            for (int q = 0; q < p; q++) begin
                if (r_req_valid[q] && (w_ridx[q] == w_ridx[p])) begin
                    w_lost = 1'b1;
                end
            end
            r_rsp_valid[p] = r_req_valid[p] & r_entry_valid[w_ridx[p]] & ~w_lost & ~w_flush;
            r_rsp_data[p*DATA_WIDTH +: DATA_WIDTH] = r_entry[w_ridx[p]];
            if (r_rsp_valid[p] && r_rsp_ready[p]) begin
                w_release[w_ridx[p]] = 1'b1;
            end
        end
    end

    assign w_entry_valid_nxt = (r_entry_valid & ~w_release) | w_wr_mask;

    // Bottom is the first live slot from the old bottom toward the new write
    // pointer; the scan runs on the wide pointer so the wrap bit stays right.
    always_comb begin
        w_dist        = w_w_ptr_nxt - r_btm_ptr;
        w_btm_ptr_nxt = w_w_ptr_nxt;
        w_found       = 1'b0;
        w_cand        = '0;
        for (int k = 0; k < SRB_DEPTH; k++) begin
            w_cand = r_btm_ptr + (IW+1)'(k);
            if (!w_found && ((IW+1)'(k) < w_dist) && w_entry_valid_nxt[w_cand[IW-1:0]]) begin
                w_btm_ptr_nxt = w_cand;
                w_found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_ptr       <= '0;
            r_btm_ptr     <= '0;
            r_entry_valid <= '0;
            for (int i = 0; i < SRB_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (w_flush) begin
            r_w_ptr       <= '0;
            r_btm_ptr     <= '0;
            r_entry_valid <= '0;
        end else begin
            r_w_ptr       <= w_w_ptr_nxt;
            r_btm_ptr     <= w_btm_ptr_nxt;
            r_entry_valid <= w_entry_valid_nxt;
            if (w_fire) begin
                r_entry[r_w_ptr[IW-1:0]] <= w_req_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_srb_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_srb_mp
// Description : Directed plus randomized bench for srb_mp against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srb_mp;

    localparam int DW = 32;
    localparam int D  = 8;
    localparam int RP = 2;
    localparam int IW = 3;
`ifdef SRB_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 w_req_valid = 1'b0;
    logic                 w_req_ready;
    logic [DW-1:0]        w_req_data = '0;
    logic [IW-1:0]        w_req_idx;
    logic [RP-1:0]        r_req_valid = '0;
    logic [RP*IW-1:0]     r_req_idx = '0;
    logic [RP-1:0]        r_req_ready;
    logic [RP-1:0]        r_rsp_valid;
    logic [RP*DW-1:0]     r_rsp_data;
    logic [RP-1:0]        r_rsp_ready = '0;
    logic [D-1:0]         entry_valid;
    logic [IW-1:0]        bottom_id;
    logic [IW:0]          used;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: payload array, queue of live sequence numbers, write count.
    logic [DW-1:0] mdata [D];
    int            live [$];
    int            wp;

    always #5 clk = ~clk;

    srb_mp #(.DATA_WIDTH(DW), .SRB_DEPTH(D), .RD_PORTS(RP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef SRB_FLUSH_EN
        .flush       (flush),
`endif
        .w_req_valid (w_req_valid),
        .w_req_ready (w_req_ready),
        .w_req_data  (w_req_data),
        .w_req_idx   (w_req_idx),
        .r_req_valid (r_req_valid),
        .r_req_idx   (r_req_idx),
        .r_req_ready (r_req_ready),
        .r_rsp_valid (r_rsp_valid),
        .r_rsp_data  (r_rsp_data),
        .r_rsp_ready (r_rsp_ready),
        .entry_valid (entry_valid),
        .bottom_id   (bottom_id),
        .used        (used)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mvalid(input int slot);
        foreach (live[i]) if ((live[i] % D) == slot) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mbottom();
        return (live.size() > 0) ? live[0] : wp;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) mdata[i] = '0;
        live.delete();
        wp = 0;
    endtask

    // One clock cycle: drive, check combinational view against the model, clock, update model.
    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic [RP-1:0] rv,
                        input logic [RP*IW-1:0] ridx, input logic [RP-1:0] rr, input logic fl);
        bit          fl_eff;
        bit          rdy_e;
        bit          rspv_e [RP];
        int          idx [RP];
        logic [D-1:0] ev_e;
        int          rel [$];
        fl_eff = fl & HAS_FLUSH;
        w_req_valid = wv; w_req_data = wd; r_req_valid = rv; r_req_idx = ridx;
        r_rsp_ready = rr; flush = fl_eff;
        #1;
        rdy_e = ((wp - mbottom()) != D) && !fl_eff;
        ev_e = '0;
        for (int s = 0; s < D; s++) ev_e[s] = mvalid(s);
        check("w_req_ready", 64'(w_req_ready), 64'(rdy_e));
        check("w_req_idx",   64'(w_req_idx),   64'(wp % D));
        check("used",        64'(used),        64'(wp - mbottom()));
        check("bottom_id",   64'(bottom_id),   64'(mbottom() % D));
        check("entry_valid", 64'(entry_valid), 64'(ev_e));
        check("r_req_ready", 64'(r_req_ready), 64'(rr));
        for (int p = 0; p < RP; p++) begin
            bit lost;
            idx[p] = int'(ridx[p*IW +: IW]);
            lost = 1'b0;
            for (int q = 0; q < p; q++) if (rv[q] && idx[q] == idx[p]) lost = 1'b1;
            rspv_e[p] = rv[p] && mvalid(idx[p]) && !lost && !fl_eff;
            check($sformatf("rsp_valid%0d", p), 64'(r_rsp_valid[p]), 64'(rspv_e[p]));
            check($sformatf("rsp_data%0d", p), 64'(r_rsp_data[p*DW +: DW]), 64'(mdata[idx[p]]));
            if (rspv_e[p] && rr[p]) rel.push_back(idx[p]);
        end
        @(posedge clk);
        if (fl_eff) begin
            live.delete();
            wp = 0;
        end else begin
            foreach (rel[r]) begin
                for (int i = 0; i < live.size(); i++) begin
                    if ((live[i] % D) == rel[r]) begin
                        live.delete(i);
                        break;
                    end
                end
            end
            if (wv && rdy_e) begin
                mdata[wp % D] = wd;
                live.push_back(wp);
                wp++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_used",   64'(used),        64'd0);
        check("rst_ev",     64'(entry_valid), 64'd0);
        check("rst_bottom", 64'(bottom_id),   64'd0);
        check("rst_widx",   64'(w_req_idx),   64'd0);
        w_req_valid = 1'b0; r_req_valid = '0; r_rsp_ready = '0; flush = 1'b0;
        #1;
        check("rst_ready",  64'(w_req_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        rst_n = 1'b1;

        // Reset read of slot 2 returns zero data and no response.
        step(1'b0, '0, 2'b01, {3'd0, 3'd2}, 2'b00, 1'b0);

        // Fill with 0xA0..0xA7.
        for (int i = 0; i < 8; i++) step(1'b1, DW'(32'hA0 + i), '0, '0, '0, 1'b0);
        check("full_used",  64'(used),        64'd8);
        check("full_ready", 64'(w_req_ready), 64'd0);
        check("full_ev",    64'(entry_valid), 64'hFF);
        check("full_btm",   64'(bottom_id),   64'd0);

        // Hole at idx 3, then bottom releases on both ports.
        step(1'b1, 32'hDEAD, 2'b01, {3'd0, 3'd3}, 2'b01, 1'b0);
        check("hole_ev",    64'(entry_valid), 64'hF7);
        check("hole_used",  64'(used),        64'd8);
        check("hole_ready", 64'(w_req_ready), 64'd0);
        step(1'b0, '0, 2'b11, {3'd1, 3'd0}, 2'b11, 1'b0);
        check("rel_btm",    64'(bottom_id),   64'd2);
        check("rel_used",   64'(used),        64'd6);

        // Conflict on idx 5, repeated next cycle.
        step(1'b0, '0, 2'b11, {3'd5, 3'd5}, 2'b11, 1'b0);
        step(1'b0, '0, 2'b11, {3'd5, 3'd5}, 2'b11, 1'b0);

        // Wrap.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, '0, '0, '0, 1'b0);
        step(1'b0, '0, 2'b11, {3'd1, 3'd0}, 2'b11, 1'b0);
        step(1'b0, '0, 2'b11, {3'd3, 3'd2}, 2'b11, 1'b0);
        check("wrap_btm0",  64'(bottom_id),   64'd4);
        check("wrap_used0", 64'(used),        64'd0);
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, '0, '0, '0, 1'b0);
        check("wrap_used",  64'(used),        64'd6);
        check("wrap_btm",   64'(bottom_id),   64'd4);

        // Same-cycle write and read of the same slot.
        do_reset();
        step(1'b1, 32'h55, 2'b01, {3'd0, 3'd0}, 2'b00, 1'b0);
        check("wr_rd_valid", 64'(r_rsp_valid[0]),     64'd1);
        check("wr_rd_data",  64'(r_rsp_data[DW-1:0]), 64'h55);

`ifdef SRB_FLUSH_EN
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, '0, '0, '0, 1'b0);
        step(1'b1, 32'h77, 2'b01, {3'd0, 3'd1}, 2'b01, 1'b1);
        check("fl_ev",   64'(entry_valid), 64'd0);
        check("fl_used", 64'(used),        64'd0);
        check("fl_btm",  64'(bottom_id),   64'd0);
        check("fl_widx", 64'(w_req_idx),   64'd0);
`endif

        // Randomized traffic with one mid-run reset.
        for (int c = 0; c < 400; c++) begin
            logic [RP-1:0]    rv;
            logic [RP*IW-1:0] ridx;
            logic [RP-1:0]    rr;
            if (c == 200) do_reset();
            for (int p = 0; p < RP; p++) begin
                if (live.size() > 0 && ($urandom % 4) != 0)
                    ridx[p*IW +: IW] = IW'(live[$urandom % live.size()] % D);
                else
                    ridx[p*IW +: IW] = IW'($urandom % D);
                rv[p] = ($urandom % 3) != 0;
                rr[p] = ($urandom % 5) != 0;
            end
            step(($urandom % 10) < 6, $urandom, rv, ridx, rr, ($urandom % 25) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/srb_mp.md
# srb_mp

Multi-port sparse read buffer. It is the parametrised successor to the single-port sparse read buffer in the ISU. Entries are written in order into a circular buffer and tagged with their slot index. Any of RD_PORTS consumers can read and release entries out of order by index. A slot is reused only after the bottom (oldest-live) pointer has moved past it.

## Interface
- DATA_WIDTH, 32, payload width per entry
- SRB_DEPTH, 8, entry count; power of two, >= 2; IW = $clog2(SRB_DEPTH)
- RD_PORTS, 2, independent read/release ports, >= 1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- w_req_valid  in  1  write request
- w_req_ready  out  1  buffer can accept a write
- w_req_data  in  DATA_WIDTH  write payload
- w_req_idx  out  IW  slot the current write lands in (equals w_ptr)
- r_req_valid  in  RD_PORTS  per-port read request
- r_req_idx  in  RD_PORTS*IW  per-port slot index; port p uses bits [p*IW +: IW]
- r_req_ready  out  RD_PORTS  per-port request ready
- r_rsp_valid  out  RD_PORTS  per-port response valid
- r_rsp_data  out  RD_PORTS*DATA_WIDTH  per-port response payload
- r_rsp_ready  in  RD_PORTS  per-port response accept
- entry_valid  out  SRB_DEPTH  live-entry bitmap
- bottom_id  out  IW  oldest live slot; equals w_ptr when empty
- used  out  IW+1  number of slots from bottom to w_ptr, holes included
- flush  in  1  synchronous flush; present only with SRB_FLUSH_EN

## Operation
- w_ptr and btm_ptr are IW+1 bits wide, with a wrap bit. used = w_ptr - btm_ptr.
- Full when used == SRB_DEPTH. w_req_ready = (used != SRB_DEPTH).
- Write handshake (valid & ready): entry[w_ptr[IW-1:0]] <= data, its valid bit is set, and w_ptr increments with wrap.
- Read port p:
  - r_req_ready[p] = r_rsp_ready[p].
  - r_rsp_valid[p] = r_req_valid[p] & entry_valid[idx_p] & ~lost_p.
  - r_rsp_data[p] = entry[idx_p]. Combinational, zero latency.
- Conflict: lost_p = 1 when some port q < p has r_req_valid[q] with idx_q == idx_p. The lowest-numbered port wins.
- Release: r_rsp_valid[p] & r_rsp_ready[p] clears entry_valid[idx_p] at the next edge.
- Bottom update on any release:
  - btm_ptr_nxt = first set bit of entry_valid_nxt, scanning circularly from btm_ptr toward w_ptr_nxt.
  - If no bit is set, btm_ptr_nxt = w_ptr_nxt.
  - The wrap bit is carried correctly so used never underflows.
- Releasing a non-bottom entry leaves a hole. btm_ptr does not move, and used is unchanged.
- Entries behind btm_ptr are never valid. A write therefore never collides with a same-cycle release.

## Timing
- Reset values:
  - w_ptr = 0, btm_ptr = 0, entry_valid = 0, entry data = 0.
  - w_req_ready = 1, w_req_idx = 0, bottom_id = 0, used = 0.
  - r_rsp_valid = 0, r_rsp_data = entry[idx] = 0.
- Write-to-read: an entry written at edge N is readable in cycle N+1. A same-cycle read of the slot being written returns r_rsp_valid = 0.
- Release-to-reuse: a bottom release at edge N raises w_req_ready in cycle N+1 when the buffer was full.
- Simultaneous write and release in one cycle: both take effect. btm_ptr_nxt accounts for the new entry, and an empty buffer plus one write yields bottom_id = old w_ptr.
- Reset may assert mid-transaction. All state returns to reset values asynchronously, and pending handshakes are dropped.

## Configuration
- SRB_FLUSH_EN defined: the flush port exists. When flush = 1:
  - w_req_ready = 0 and all r_rsp_valid = 0 that cycle.
  - Next edge: entry_valid = 0, w_ptr = 0, btm_ptr = 0. Data is retained.
- SRB_FLUSH_EN undefined: no flush port and no flush logic. Behaviour is otherwise identical.

## Test plan
- Reset, then 8 writes 0xA0..0xA7 with no reads. Required: w_req_idx 0..7, used = 8, w_req_ready = 0 after the 8th, entry_valid = 0xFF, bottom_id = 0.
- Full buffer; port 0 releases idx 3. Required: entry_valid = 0xF7, bottom_id = 0, used = 8, w_req_ready still 0. Then release idx 0 and idx 1 on ports 0 and 1 in the same cycle. Required: bottom_id = 2, used = 6, w_req_ready = 1.
- Both ports request idx 5 with data 0xA5 and both rsp_ready = 1. Required: only r_rsp_valid[0] = 1 with data 0xA5; entry 5 cleared; port 1 gets valid = 0 that cycle and next.
- Wrap: 4 writes; release 0..3 so bottom = 4, used = 0; then 6 more writes. Required: w_req_idx 4,5,6,7,0,1; used = 6; bottom_id = 4.
- Empty buffer, write 0x55 while port 0 reads the same idx. Required: r_rsp_valid[0] = 0 that cycle, 1 with data 0x55 next cycle.
- SRB_FLUSH_EN: 5 entries live, flush pulsed with a concurrent write. Required: write not accepted; next cycle entry_valid = 0, used = 0, bottom_id = 0, w_req_idx = 0.
